serial_complementer_n: RTL and testbench

SERIAL_COMPLEMENTER_N -- requirements
Module: serial_complementer_n

---
 rtl/serial_complementer_n_if.sv | 61 ++++++
 rtl/serial_complementer_n.sv | 153 +++++++++++++++
 tb/tb_serial_complementer_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_complementer_n_if.sv
// ---------------------------------------------------------------------------
// serial_complementer_n_if
//
// Purpose:
//   Bundles the operand/control inputs and the serial/parallel result outputs
//   of serial_complementer_n. Clock and reset stay as plain module ports.
//
// Signals:
//   data    [WIDTH-1:0]  parallel operand, sampled when a start is accepted
//   mode    [1:0]        00 pass, 01 ones complement, 1x twos complement
//   start                request to begin a conversion
//   abort                cancel the conversion in progress
//   y                    serial result bit, LSB first
//   y_valid              high while y carries a result bit
//   busy                 high while a conversion is shifting or completing
//   done                 one-cycle completion pulse
//   result  [WIDTH-1:0]  parallel copy of the last completed conversion
//
// Modports:
//   master  drives the request side (testbench / upstream logic)
//   slave   the converter itself
// ---------------------------------------------------------------------------
interface serial_complementer_n_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
    logic             start;
    logic             abort;
    logic             y;
    logic             y_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output data,
        output mode,
        output start,
        output abort,
        input  y,
        input  y_valid,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  data,
        input  mode,
        input  start,
        input  abort,
        output y,
        output y_valid,
        output busy,
        output done,
        output result
    );

endinterface

// File: rtl/serial_complementer_n.sv
// ---------------------------------------------------------------------------
// serial_complementer_n
//
// Purpose:
//   Bit-serial pass / ones-complement / twos-complement converter. A parallel
//   operand is loaded on an accepted start, streamed out LSB first on y over
//   WIDTH cycles, and the assembled word is published on result together
//   with a one-cycle done pulse.
//
// Ports:
//   Clock     in   rising-edge clock for all state
//   reset_b   in   asynchronous active-low reset
//   bus       slave modport of serial_complementer_n_if (data, mode, start,
//             abort in; y, y_valid, busy, done, result out)
//
// Parameters:
//   WIDTH     operand width in bits, must be at least 2; the interface
//             instance connected to bus must use the same WIDTH.
//
// Twos complement is done serially with the classic rule: copy bits up to
// and including the first 1 seen from the LSB, invert every bit after it.
// The "one seen" flag tracks whether that first 1 has already gone by.
// ---------------------------------------------------------------------------
module serial_complementer_n #(
    parameter int WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   reset_b,
    serial_complementer_n_if.slave bus
);

    // Counter is $clog2(WIDTH) bits; it counts 0..WIDTH-1 and holds at the
    // last value instead of wrapping.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] build_reg;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    bit_count;
    logic [1:0]       mode_q;
    logic             one_seen;
    logic             y_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             y_bit;

    // Output bit for the current SHIFT cycle, derived from the bit at the
    // bottom of the shift register, the one-seen flag and the latched mode.
    // Forced low outside SHIFT so y is quiet whenever y_valid is low.
    always_comb begin
        y_bit = 1'b0;
        if (state == SHIFT) begin
            case (mode_q)
                2'b00:   y_bit = shift_reg[0];
                2'b01:   y_bit = ~shift_reg[0];
                default: y_bit = shift_reg[0] ^ one_seen;
            endcase
        end
    end

    // Control FSM plus datapath registers. y_valid, busy and done are kept
    // as flops updated alongside the state so they always match the state
    // that is entered on the same edge.
    // Abort takes priority over the final-bit transition, so an abort on
    // the last SHIFT cycle still produces no done pulse and leaves result
    // untouched. Start is only looked at in IDLE, and abort is not looked at
    // there at all, which gives start priority when both are high.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            shift_reg <= '0;
            build_reg <= '0;
            result_q  <= '0;
            bit_count <= '0;
            mode_q    <= 2'b00;
            one_seen  <= 1'b0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shift_reg <= bus.data;
                        mode_q    <= bus.mode;
                        one_seen  <= 1'b0;
                        bit_count <= '0;
                        state     <= SHIFT;
                        y_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        y_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        y_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end else begin
                        shift_reg <= shift_reg >> 1;
                        one_seen  <= one_seen | shift_reg[0];
                        // Each result bit enters at the MSB, so after WIDTH
                        // shifts the first bit produced sits at bit 0.
                        build_reg <= {y_bit, build_reg[WIDTH-1:1]};
                        if (bit_count == LAST_BIT) begin
                            // Publish the fully assembled word, including
                            // the bit produced in this final cycle.
                            result_q  <= {y_bit, build_reg[WIDTH-1:1]};
                            state     <= DONE;
                            y_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            bit_count <= bit_count + CW'(1);
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    y_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y       = y_bit;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;

endmodule

// File: tb/tb_serial_complementer_n.sv
// ---------------------------------------------------------------------------
// tb_serial_complementer_n
//
// Purpose:
//   Directed, table-driven bench for serial_complementer_n. An 8-bit
//   instance runs a table of operand/mode/result vectors plus hand-written
//   abort and mid-conversion reset sequences; a 16-bit instance runs one
//   wide conversion. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_serial_complementer_n;

    logic Clock;
    logic reset_b;

    int checks;
    int failures;

    serial_complementer_n_if #(.WIDTH(8))  bus8 ();
    serial_complementer_n_if #(.WIDTH(16)) bus16 ();

    serial_complementer_n #(.WIDTH(8)) u_dut8 (
        .Clock   (Clock),
        .reset_b (reset_b),
        .bus     (bus8)
    );

    serial_complementer_n #(.WIDTH(16)) u_dut16 (
        .Clock   (Clock),
        .reset_b (reset_b),
        .bus     (bus16)
    );

    // Free-running clock, 10 time-unit period.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [7:0] expected;
    } vector_t;

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Present an operand for one edge on the 8-bit instance; returns 1 time
    // unit after the accepting edge, i.e. in the first SHIFT cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode);
        @(negedge Clock);
        bus8.data  = data;
        bus8.mode  = mode;
        bus8.start = 1'b1;
        @(posedge Clock);
        #1;
        bus8.start = 1'b0;
    endtask

    // Full conversion: 8 valid bits matching expected LSB first, done in the
    // cycle after the last bit, then back to idle.
    task automatic runConversion(input logic [7:0] data, input logic [1:0] mode,
                                 input logic [7:0] expected);
        applyStimulus(data, mode);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("y_valid[%0d]", i), 32'(bus8.y_valid), 32'd1);
            checkOutput($sformatf("y[%0d]", i), 32'(bus8.y), 32'(expected[i]));
            checkOutput($sformatf("busy[%0d]", i), 32'(bus8.busy), 32'd1);
            checkOutput($sformatf("done_early[%0d]", i), 32'(bus8.done), 32'd0);
            @(posedge Clock);
            #1;
        end
        checkOutput("done_pulse", 32'(bus8.done), 32'd1);
        checkOutput("y_valid_in_done", 32'(bus8.y_valid), 32'd0);
        checkOutput("y_in_done", 32'(bus8.y), 32'd0);
        checkOutput("busy_in_done", 32'(bus8.busy), 32'd1);
        checkOutput("result", 32'(bus8.result), 32'(expected));
        @(posedge Clock);
        #1;
        checkOutput("done_cleared", 32'(bus8.done), 32'd0);
        checkOutput("busy_cleared", 32'(bus8.busy), 32'd0);
        checkOutput("result_held", 32'(bus8.result), 32'(expected));
    endtask

    vector_t vectors[9];
    logic [7:0] previous_result;

    initial begin
        checks   = 0;
        failures = 0;

        vectors[0] = '{data: 8'h5A, mode: 2'b10, expected: 8'hA6};
        vectors[1] = '{data: 8'h5A, mode: 2'b01, expected: 8'hA5};
        vectors[2] = '{data: 8'h5A, mode: 2'b00, expected: 8'h5A};
        vectors[3] = '{data: 8'h00, mode: 2'b10, expected: 8'h00};
        vectors[4] = '{data: 8'h80, mode: 2'b10, expected: 8'h80};
        vectors[5] = '{data: 8'h5A, mode: 2'b11, expected: 8'hA6};
        vectors[6] = '{data: 8'h01, mode: 2'b10, expected: 8'hFF};
        vectors[7] = '{data: 8'h3C, mode: 2'b10, expected: 8'hC4};
        vectors[8] = '{data: 8'hF0, mode: 2'b01, expected: 8'h0F};

        bus8.data   = 8'h00;
        bus8.mode   = 2'b00;
        bus8.start  = 1'b0;
        bus8.abort  = 1'b0;
        bus16.data  = 16'h0000;
        bus16.mode  = 2'b00;
        bus16.start = 1'b0;
        bus16.abort = 1'b0;

        // Reset state.
        reset_b = 1'b0;
        #12;
        checkOutput("reset_y", 32'(bus8.y), 32'd0);
        checkOutput("reset_y_valid", 32'(bus8.y_valid), 32'd0);
        checkOutput("reset_busy", 32'(bus8.busy), 32'd0);
        checkOutput("reset_done", 32'(bus8.done), 32'd0);
        checkOutput("reset_result", 32'(bus8.result), 32'd0);
        @(negedge Clock);
        reset_b = 1'b1;

        // Idle with no start stays idle.
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("idle_y_valid", 32'(bus8.y_valid), 32'd0);
        checkOutput("idle_busy", 32'(bus8.busy), 32'd0);

        // Table of complete conversions.
        for (int v = 0; v < 9; v++) begin
            runConversion(vectors[v].data, vectors[v].mode, vectors[v].expected);
        end

        // Abort after three bits; start during SHIFT must be ignored.
        runConversion(8'h5A, 2'b10, 8'hA6);
        previous_result = 8'hA6;
        applyStimulus(8'h01, 2'b10);
        checkOutput("abort_seq_y0", 32'(bus8.y), 32'd1);
        @(negedge Clock);
        bus8.start = 1'b1;
        bus8.data  = 8'h00;
        @(posedge Clock);
        #1;
        bus8.start = 1'b0;
        checkOutput("abort_seq_y1", 32'(bus8.y), 32'd1);
        checkOutput("abort_seq_valid1", 32'(bus8.y_valid), 32'd1);
        @(posedge Clock);
        #1;
        checkOutput("abort_seq_y2", 32'(bus8.y), 32'd1);
        @(negedge Clock);
        bus8.abort = 1'b1;
        @(posedge Clock);
        #1;
        bus8.abort = 1'b0;
        checkOutput("abort_y_valid", 32'(bus8.y_valid), 32'd0);
        checkOutput("abort_busy", 32'(bus8.busy), 32'd0);
        checkOutput("abort_done", 32'(bus8.done), 32'd0);
        checkOutput("abort_result", 32'(bus8.result), 32'(previous_result));
        for (int i = 0; i < 9; i++) begin
            @(posedge Clock);
            #1;
            checkOutput("abort_no_done", 32'(bus8.done), 32'd0);
        end
        checkOutput("abort_result_after", 32'(bus8.result), 32'(previous_result));

        // Start and abort together in idle: start wins.
        @(negedge Clock);
        bus8.abort = 1'b1;
        applyStimulus(8'h5A, 2'b01);
        bus8.abort = 1'b0;
        checkOutput("start_wins_valid", 32'(bus8.y_valid), 32'd1);
        checkOutput("start_wins_y0", 32'(bus8.y), 32'd1);
        repeat (8) @(posedge Clock);
        #1;
        checkOutput("start_wins_done", 32'(bus8.done), 32'd1);
        checkOutput("start_wins_result", 32'(bus8.result), 32'hA5);
        @(posedge Clock);
        #1;

        // Asynchronous reset in the middle of a conversion.
        applyStimulus(8'h5A, 2'b01);
        @(posedge Clock);
        #1;
        checkOutput("pre_reset_valid", 32'(bus8.y_valid), 32'd1);
        @(negedge Clock);
        reset_b = 1'b0;
        #1;
        checkOutput("midreset_y", 32'(bus8.y), 32'd0);
        checkOutput("midreset_y_valid", 32'(bus8.y_valid), 32'd0);
        checkOutput("midreset_busy", 32'(bus8.busy), 32'd0);
        checkOutput("midreset_done", 32'(bus8.done), 32'd0);
        checkOutput("midreset_result", 32'(bus8.result), 32'd0);
        @(negedge Clock);
        reset_b = 1'b1;
        runConversion(8'h5A, 2'b10, 8'hA6);

        // 16-bit instance: twos complement of 1 is all ones, done at cycle 17.
        @(negedge Clock);
        bus16.data  = 16'h0001;
        bus16.mode  = 2'b10;
        bus16.start = 1'b1;
        @(posedge Clock);
        #1;
        bus16.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("w16_valid[%0d]", i), 32'(bus16.y_valid), 32'd1);
            checkOutput($sformatf("w16_y[%0d]", i), 32'(bus16.y), 32'd1);
            checkOutput($sformatf("w16_done_early[%0d]", i), 32'(bus16.done), 32'd0);
            @(posedge Clock);
            #1;
        end
        checkOutput("w16_done", 32'(bus16.done), 32'd1);
        checkOutput("w16_result", 32'(bus16.result), 32'hFFFF);
        @(posedge Clock);
        #1;
        checkOutput("w16_done_cleared", 32'(bus16.done), 32'd0);
        checkOutput("w16_busy_cleared", 32'(bus16.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
